// File: rtl/pipe_interlock_ctrl.sv
// Stall/interlock controller: load-use bubble, HI/LO scoreboard for the
// multi-cycle MDU, MDU start pulses and a saturating stall-cycle counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no MDU operation in flight, HI/LO valid
//   BUSY  | MDU operation in flight; mcnt counts down, result at mcnt==0
module pipe_interlock_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             d_mdu,
    input  logic             d_hilo_rd,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    output logic             wpcir,
    output logic             e_bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic             hilo_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MW = $clog2(MDU_LAT);
    localparam logic [MW-1:0] RELOAD = MW'(MDU_LAT - 1);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic             state_q, state_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu, mwait, stall;

    // A load to $0 never produces a value, so it can never cause a hazard.
    assign lu = ewreg & em2reg & (ern != 5'd0) &
                ((d_use_rs & (ern == d_rs)) | (d_use_rt & (ern == d_rt)));

    assign mdu_busy   = (state_q == BUSY) & (mcnt_q != '0);
    assign mwait      = mdu_busy & (d_hilo_rd | d_mdu);
    assign stall      = lu | mwait;

    assign wpcir      = ~stall;
    assign e_bubble   = stall;
    assign mdu_start  = d_mdu & ~stall;
    assign hilo_ready = ~mdu_busy;
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_start) begin
                    state_d = BUSY;
                    mcnt_d  = RELOAD;
                end
            end
            BUSY: begin
                if (mcnt_q != '0) begin
                    mcnt_d = mcnt_q - MW'(1);
                end else if (mdu_start) begin
                    // back-to-back op: reload without passing through IDLE
                    mcnt_d = RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                mcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
// Scoreboard bench for pipe_interlock_ctrl: a cycle-indexed reference model
// pushes expected outputs each cycle, popped and compared mid-cycle.
module tb_pipe_interlock_ctrl;

    localparam int LAT = 32;
    localparam int W   = 16;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic [4:0]   d_rs, d_rt, ern;
    logic         d_use_rs, d_use_rt, d_mdu, d_hilo_rd, ewreg, em2reg;
    logic         wpcir, e_bubble, mdu_start, mdu_busy, hilo_ready;
    logic [W-1:0] stall_cnt;

    pipe_interlock_ctrl #(.MDU_LAT(LAT), .CNT_W(W)) dut (
        .clock(clock), .resetn(resetn),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_mdu(d_mdu), .d_hilo_rd(d_hilo_rd),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .wpcir(wpcir), .e_bubble(e_bubble), .mdu_start(mdu_start),
        .mdu_busy(mdu_busy), .hilo_ready(hilo_ready), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       wpcir;
        logic       bubble;
        logic       start;
        logic       busy;
        logic       ready;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t sbq[$];

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: the cycle index at which HI/LO next becomes valid
    int cyc       = 0;
    int ready_cyc = 0;
    int cnt_m     = 0;
    logic stall_m, start_m;

    logic obs_wpcir, obs_start, obs_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic set_quiet();
        d_rs = 5'd1; d_rt = 5'd2; ern = 5'd0;
        d_use_rs = 1'b0; d_use_rt = 1'b0; d_mdu = 1'b0; d_hilo_rd = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ewreg = 1'b1; em2reg = 1'b1; ern = r; d_rs = r; d_use_rs = 1'b1;
    endtask

    // one pipeline cycle: inputs already driven at posedge+1
    task automatic step();
        exp_t e, o;
        logic lu_m, busy_m;
        lu_m = ewreg & em2reg & (ern != 5'd0) &
               ((d_use_rs & (ern == d_rs)) | (d_use_rt & (ern == d_rt)));
        busy_m  = (cyc < ready_cyc);
        stall_m = lu_m | (busy_m & (d_hilo_rd | d_mdu));
        start_m = d_mdu & ~stall_m;
        e.wpcir = ~stall_m; e.bubble = stall_m; e.start = start_m;
        e.busy = busy_m; e.ready = ~busy_m; e.cnt = W'(cnt_m);
        sbq.push_back(e);
        @(negedge clock);
        o = sbq.pop_front();
        check("wpcir",      32'(wpcir),      32'(o.wpcir));
        check("e_bubble",   32'(e_bubble),   32'(o.bubble));
        check("mdu_start",  32'(mdu_start),  32'(o.start));
        check("mdu_busy",   32'(mdu_busy),   32'(o.busy));
        check("hilo_ready", 32'(hilo_ready), 32'(o.ready));
        check("stall_cnt",  32'(stall_cnt),  32'(o.cnt));
        obs_wpcir = wpcir; obs_start = mdu_start; obs_busy = mdu_busy;
        @(posedge clock);
        if (stall_m && cnt_m != (1 << W) - 1) cnt_m++;
        if (start_m) ready_cyc = cyc + LAT;
        cyc++;
        #1;
    endtask

    int n, cnt_before;

    initial begin
        set_quiet();
        #2;
        check("rst_wpcir",      32'(wpcir),      32'd1);
        check("rst_e_bubble",   32'(e_bubble),   32'd0);
        check("rst_mdu_start",  32'(mdu_start),  32'd0);
        check("rst_mdu_busy",   32'(mdu_busy),   32'd0);
        check("rst_hilo_ready", 32'(hilo_ready), 32'd1);
        check("rst_stall_cnt",  32'(stall_cnt),  32'd0);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;

        // 1: load-use, one bubble
        set_lu(5'd5); step();
        check("t1_stalled", 32'(obs_wpcir), 32'd0);
        set_quiet(); step();
        check("t1_cnt", 32'(stall_cnt), 32'd1);

        // 2: load to $0, then ALU producer
        set_lu(5'd0); step();
        set_quiet(); ewreg = 1'b1; ern = 5'd7; d_rt = 5'd7; d_use_rt = 1'b1; step();
        check("t2_cnt", 32'(stall_cnt), 32'd1);

        // 3: MULT then MFHI
        set_quiet(); d_mdu = 1'b1; step();
        check("t3_start", 32'(obs_start), 32'd1);
        cnt_before = int'(stall_cnt);
        set_quiet(); d_hilo_rd = 1'b1;
        n = 0;
        do begin step(); if (!obs_wpcir) n++; end while (!obs_wpcir && n < 100);
        check("t3_stalls", 32'(n), 32'd31);
        check("t3_cnt", 32'(stall_cnt), 32'(cnt_before + 31));
        set_quiet(); step();

        // 4: MULT followed by independent ADDs
        d_mdu = 1'b1; step();
        cnt_before = int'(stall_cnt);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            set_quiet();
            if (i < 5) begin
                d_rs = 5'(i + 8); d_rt = 5'(i + 9); d_use_rs = 1'b1; d_use_rt = 1'b1;
                ewreg = 1'b1; ern = 5'(i + 20);
            end
            step();
            if (!obs_busy) break;
            n++;
        end
        check("t4_busy_cycles", 32'(n), 32'd31);
        check("t4_no_stall", 32'(stall_cnt), 32'(cnt_before));

        // 5: DIV while BUSY, back-to-back start at mcnt==0
        set_quiet(); d_mdu = 1'b1; step();
        n = 0;
        do begin step(); if (!obs_start) n++; end while (!obs_start && n < 100);
        check("t5_wait", 32'(n), 32'd31);
        set_quiet(); step();
        check("t5_busy_after_reload", 32'(obs_busy), 32'd1);
        repeat (31) step();
        check("t5_done", 32'(obs_busy), 32'd0);

        // 6: lu and d_mdu together
        set_lu(5'd3); d_mdu = 1'b1; step();
        check("t6_no_start", 32'(obs_start), 32'd0);
        ewreg = 1'b0; step();
        check("t6_start", 32'(obs_start), 32'd1);
        set_quiet(); d_hilo_rd = 1'b1;
        repeat (21) step();
        #2;
        check("t6_busy_pre", 32'(mdu_busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_arst_busy",  32'(mdu_busy),   32'd0);
        check("t6_arst_ready", 32'(hilo_ready), 32'd1);
        check("t6_arst_wpcir", 32'(wpcir),      32'd1);
        check("t6_arst_cnt",   32'(stall_cnt),  32'd0);
        ready_cyc = 0; cnt_m = 0;
        @(negedge clock); #1 resetn = 1'b1;
        @(posedge clock); cyc++; #1;

        // saturation of stall_cnt
        set_quiet(); set_lu(5'd9);
        repeat ((1 << W) + 5) step();
        check("t6_saturate", 32'(stall_cnt), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
